s2mm_cmd_sequencer: RTL and testbench

- Drives the datamover S2MM command and status streams so the ADC stream is written continuously into a ring of fixed-size DDR blocks.
- Keeps up to MAX_OUT commands in flight, checks every status word, and reports completed blocks to the readback side.
- Sits between the system block's S2MM CMD/STS AXI-Stream ports and the capture control logic.

---
 rtl/s2mm_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_s2mm_cmd_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_cmd_sequencer.sv
// S2MM command/status sequencer: streams fixed-size block commands around a DDR ring,
// keeps up to MAX_OUT in flight and checks every returned status in issue order.
module s2mm_cmd_sequencer #(
  parameter logic [22:0] BTT        = 23'h00_1000,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_BLOCKS = 16,
  parameter int unsigned MAX_OUT    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic [71:0]                   cmd_tdata,
  output logic                          cmd_tvalid,
  input  logic                          cmd_tready,
  input  logic [7:0]                    sts_tdata,
  input  logic                          sts_tvalid,
  output logic                          sts_tready,
  output logic                          busy,
  output logic                          done_pulse,
  output logic [$clog2(NUM_BLOCKS)-1:0] done_block,
  output logic [31:0]                   done_count,
  output logic                          err,
  output logic [7:0]                    err_sts
);

  localparam int unsigned IW = $clog2(NUM_BLOCKS);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCKS - 1);
  localparam logic [OW-1:0] MAX_CNT  = OW'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   issue_idx_q, issue_idx_d;
  logic [IW-1:0]   comp_idx_q, comp_idx_d;
  logic [3:0]      issue_tag_q, issue_tag_d;
  logic [3:0]      exp_tag_q, exp_tag_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic            cmd_tvalid_q, cmd_tvalid_d;
  logic [71:0]     cmd_tdata_q, cmd_tdata_d;
  logic            sts_tready_q;
  logic            done_pulse_q, done_pulse_d;
  logic [IW-1:0]   done_block_q, done_block_d;
  logic [31:0]     done_count_q, done_count_d;
  logic            err_q, err_d;
  logic [7:0]      err_sts_q, err_sts_d;

  logic            cmd_accept, sts_fire, sts_expected, sts_ok, sts_bad;
  logic [31:0]     saddr;

  assign cmd_accept   = cmd_tvalid_q & cmd_tready;
  assign sts_fire     = sts_tvalid & sts_tready_q;
  assign sts_expected = (outst_q != '0);
  assign sts_ok       = (sts_tdata[7:4] == 4'b1000) && (sts_tdata[3:0] == exp_tag_q) && sts_expected;
  assign sts_bad      = sts_fire & ~sts_ok;
  assign saddr        = BASE_ADDR + 32'(issue_idx_q) * 32'(BTT);

  always_comb begin
    state_d      = state_q;
    issue_idx_d  = issue_idx_q;
    comp_idx_d   = comp_idx_q;
    issue_tag_d  = issue_tag_q;
    exp_tag_d    = exp_tag_q;
    outst_d      = outst_q;
    cmd_tvalid_d = cmd_tvalid_q;
    cmd_tdata_d  = cmd_tdata_q;
    done_pulse_d = 1'b0;
    done_block_d = done_block_q;
    done_count_d = done_count_q;
    err_d        = err_q;
    err_sts_d    = err_sts_q;

    // An error seen this cycle already blocks a new issue from IDLE.
    case (state_q)
      IDLE: begin
        if (err_q || sts_bad) begin
          state_d = HALT;
        end else if (enable && (outst_q < MAX_CNT)) begin
          state_d      = ISSUE;
          cmd_tvalid_d = 1'b1;
          cmd_tdata_d  = {4'h0, issue_tag_q, saddr, 8'h00, 1'b1, BTT};
        end
      end
      ISSUE: begin
        if (cmd_accept) begin
          state_d      = IDLE;
          cmd_tvalid_d = 1'b0;
          issue_idx_d  = (issue_idx_q == LAST_IDX) ? '0 : issue_idx_q + 1'b1;
          issue_tag_d  = issue_tag_q + 4'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    case ({cmd_accept, sts_fire && sts_expected})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (sts_fire && sts_expected) begin
      exp_tag_d  = exp_tag_q + 4'd1;
      comp_idx_d = (comp_idx_q == LAST_IDX) ? '0 : comp_idx_q + 1'b1;
    end

    if (sts_fire && sts_ok) begin
      done_pulse_d = 1'b1;
      done_block_d = comp_idx_q;
      done_count_d = done_count_q + 32'd1;
    end

    if (sts_bad) begin
      err_d = 1'b1;
      if (!err_q) err_sts_d = sts_tdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      issue_idx_q  <= '0;
      comp_idx_q   <= '0;
      issue_tag_q  <= '0;
      exp_tag_q    <= '0;
      outst_q      <= '0;
      cmd_tvalid_q <= 1'b0;
      cmd_tdata_q  <= '0;
      sts_tready_q <= 1'b0;
      done_pulse_q <= 1'b0;
      done_block_q <= '0;
      done_count_q <= '0;
      err_q        <= 1'b0;
      err_sts_q    <= '0;
    end else begin
      state_q      <= state_d;
      issue_idx_q  <= issue_idx_d;
      comp_idx_q   <= comp_idx_d;
      issue_tag_q  <= issue_tag_d;
      exp_tag_q    <= exp_tag_d;
      outst_q      <= outst_d;
      cmd_tvalid_q <= cmd_tvalid_d;
      cmd_tdata_q  <= cmd_tdata_d;
      sts_tready_q <= 1'b1;
      done_pulse_q <= done_pulse_d;
      done_block_q <= done_block_d;
      done_count_q <= done_count_d;
      err_q        <= err_d;
      err_sts_q    <= err_sts_d;
    end
  end

  assign cmd_tdata  = cmd_tdata_q;
  assign cmd_tvalid = cmd_tvalid_q;
  assign sts_tready = sts_tready_q;
  assign busy       = (state_q != IDLE) || (outst_q != '0);
  assign done_pulse = done_pulse_q;
  assign done_block = done_block_q;
  assign done_count = done_count_q;
  assign err        = err_q;
  assign err_sts    = err_sts_q;

endmodule

// File: tb/tb_s2mm_cmd_sequencer.sv
// Scoreboard bench for s2mm_cmd_sequencer: expected commands and completions are
// queued by the stimulus, and negedge monitors pop and compare on each DUT output.
module tb_s2mm_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid;
  logic        sts_tready;
  logic        busy;
  logic        done_pulse;
  logic [3:0]  done_block;
  logic [31:0] done_count;
  logic        err;
  logic [7:0]  err_sts;

  always #5 clk = ~clk;

  s2mm_cmd_sequencer #(
    .BTT        (23'h00_1000),
    .BASE_ADDR  (32'h0000_0000),
    .NUM_BLOCKS (16),
    .MAX_OUT    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_tdata  (cmd_tdata),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .sts_tdata  (sts_tdata),
    .sts_tvalid (sts_tvalid),
    .sts_tready (sts_tready),
    .busy       (busy),
    .done_pulse (done_pulse),
    .done_block (done_block),
    .done_count (done_count),
    .err        (err),
    .err_sts    (err_sts)
  );

  typedef struct {int due; logic [7:0] data;} sts_ent_t;
  typedef struct {logic [3:0] blk; logic [31:0] cnt;} done_ent_t;

  sts_ent_t    sts_q[$];
  logic [71:0] exp_cmd_q[$];
  done_ent_t   exp_done_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  bit          auto_resp = 1'b0;
  logic [3:0]  resp_tag = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got unexpected output expected none", name);
  endtask

  function automatic logic [71:0] mk_cmd(input int n);
    logic [3:0]  t;
    logic [31:0] a;
    t = 4'(n % 16);
    a = 32'(n % 16) * 32'h0000_1000;
    return {4'h0, t, a, 8'h00, 1'b1, 23'h001000};
  endfunction

  // Monitors: command handshakes and completion pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_tvalid && cmd_tready) begin
        acc_cnt++;
        if (exp_cmd_q.size() == 0) fail("unexpected_cmd");
        else check("cmd_tdata", cmd_tdata, exp_cmd_q.pop_front());
        if (auto_resp) begin
          sts_q.push_back('{cyc + 10, {4'h8, resp_tag}});
          resp_tag++;
        end
      end
      if (done_pulse) begin
        if (exp_done_q.size() == 0) fail("unexpected_done");
        else begin
          done_ent_t e;
          e = exp_done_q.pop_front();
          check("done_block", 72'(done_block), 72'(e.blk));
          check("done_count", 72'(done_count), 72'(e.cnt));
        end
      end
    end
  end

  // Status driver, slightly after the main stimulus so a same-cycle push lands this cycle.
  initial begin
    sts_tvalid = 1'b0;
    sts_tdata  = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (sts_q.size() > 0 && sts_q[0].due <= cyc) begin
        sts_tvalid = 1'b1;
        sts_tdata  = sts_q[0].data;
        void'(sts_q.pop_front());
      end else begin
        sts_tvalid = 1'b0;
        sts_tdata  = 8'h00;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    cmd_tready = 1'b0;
    reset      = 1'b1;
    auto_resp  = 1'b0;
    resp_tag   = 4'h0;
    acc_cnt    = 0;
    sts_q.delete();
    exp_cmd_q.delete();
    exp_done_q.delete();
    tick(3);
    check("rst_cmd_tvalid", 72'(cmd_tvalid), 72'd0);
    check("rst_sts_tready", 72'(sts_tready), 72'd0);
    check("rst_busy",       72'(busy),       72'd0);
    check("rst_done_pulse", 72'(done_pulse), 72'd0);
    check("rst_done_block", 72'(done_block), 72'd0);
    check("rst_done_count", 72'(done_count), 72'd0);
    check("rst_err",        72'(err),        72'd0);
    check("rst_err_sts",    72'(err_sts),    72'd0);
    reset = 1'b0;
    tick(1);
    check("post_rst_sts_tready", 72'(sts_tready), 72'd1);
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int i = 0;
    while (acc_cnt < n && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 72'(acc_cnt), 72'(n));
  endtask

  task automatic wait_done_empty(input int budget, input string name);
    int i = 0;
    while (exp_done_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 72'(exp_done_q.size()), 72'd0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i = 0;
    while (busy && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 72'(busy), 72'd0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i = 0;
    while (!cmd_tvalid && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 72'(cmd_tvalid), 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    cmd_tready = 1'b0;

    // Continuous streaming with ring wrap: 17 commands, status 10 cycles after each.
    do_reset();
    exp_cmd_q.push_back(72'h000000000000801000);
    exp_cmd_q.push_back(72'h010000100000801000);
    for (int n = 2; n < 17; n++) exp_cmd_q.push_back(mk_cmd(n));
    for (int n = 0; n < 17; n++) exp_done_q.push_back('{4'(n % 16), 32'(n + 1)});
    auto_resp  = 1'b1;
    cmd_tready = 1'b1;
    enable     = 1'b1;
    wait_acc(17, 600, "p1_issue_count");
    enable = 1'b0;
    wait_done_empty(300, "p1_done_drain");
    wait_idle(20, "p1_busy_fall");
    check("p1_done_count", 72'(done_count), 72'd17);
    check("p1_done_block", 72'(done_block), 72'd0);
    check("p1_cmd_drain",  72'(exp_cmd_q.size()), 72'd0);
    check("p1_err",        72'(err), 72'd0);

    // Credit limit.
    do_reset();
    for (int n = 0; n < 3; n++) exp_cmd_q.push_back(mk_cmd(n));
    for (int n = 0; n < 3; n++) exp_done_q.push_back('{4'(n), 32'(n + 1)});
    cmd_tready = 1'b1;
    enable     = 1'b1;
    wait_acc(2, 20, "p2_two_issued");
    tick(20);
    check("p2_credit_count", 72'(acc_cnt), 72'd2);
    check("p2_tvalid_low",   72'(cmd_tvalid), 72'd0);
    check("p2_busy",         72'(busy), 72'd1);
    sts_q.push_back('{cyc, 8'h80});
    wait_acc(3, 3, "p2_third_issue");
    enable = 1'b0;
    sts_q.push_back('{cyc, 8'h81});
    sts_q.push_back('{cyc + 1, 8'h82});
    wait_done_empty(30, "p2_done_drain");
    wait_idle(10, "p2_busy_fall");
    check("p2_cmd_drain", 72'(exp_cmd_q.size()), 72'd0);

    // Backpressure with enable dropping mid-handshake.
    do_reset();
    exp_cmd_q.push_back(mk_cmd(0));
    exp_done_q.push_back('{4'd0, 32'd1});
    auto_resp  = 1'b1;
    cmd_tready = 1'b0;
    enable     = 1'b1;
    wait_valid(5, "p3_valid_rise");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("p3_hold_valid", 72'(cmd_tvalid), 72'd1);
      check("p3_hold_data",  cmd_tdata, 72'h000000000000801000);
      tick(1);
      if (i == 2) enable = 1'b0;
    end
    cmd_tready = 1'b1;
    wait_acc(1, 3, "p3_accept");
    wait_done_empty(20, "p3_done");
    wait_idle(5, "p3_busy_fall");
    tick(5);
    check("p3_no_more_cmds", 72'(acc_cnt), 72'd1);

    // Error status halts issue but status handling continues.
    do_reset();
    for (int n = 0; n < 3; n++) exp_cmd_q.push_back(mk_cmd(n));
    exp_done_q.push_back('{4'd0, 32'd1});
    cmd_tready = 1'b1;
    enable     = 1'b1;
    wait_acc(2, 20, "p4_two_issued");
    sts_q.push_back('{cyc, 8'h80});
    wait_acc(3, 6, "p4_third_issued");
    sts_q.push_back('{cyc, 8'h41});
    tick(3);
    check("p4_err",        72'(err), 72'd1);
    check("p4_err_sts",    72'(err_sts), 72'h41);
    check("p4_done_count", 72'(done_count), 72'd1);
    tick(10);
    check("p4_halted",     72'(acc_cnt), 72'd3);
    check("p4_tvalid_low", 72'(cmd_tvalid), 72'd0);
    check("p4_sts_tready", 72'(sts_tready), 72'd1);
    exp_done_q.push_back('{4'd2, 32'd2});
    sts_q.push_back('{cyc, 8'h82});
    wait_done_empty(10, "p4_late_good");
    check("p4_late_count", 72'(done_count), 72'd2);
    sts_q.push_back('{cyc, 8'h83});
    tick(4);
    check("p4_first_err_kept", 72'(err_sts), 72'h41);
    check("p4_unexp_no_done",  72'(done_count), 72'd2);
    check("p4_halt_busy",      72'(busy), 72'd1);

    // Same-cycle accept and status, then asynchronous reset mid-ISSUE.
    do_reset();
    for (int n = 0; n < 3; n++) exp_cmd_q.push_back(mk_cmd(n));
    exp_done_q.push_back('{4'd0, 32'd1});
    exp_done_q.push_back('{4'd1, 32'd2});
    cmd_tready = 1'b1;
    enable     = 1'b1;
    wait_acc(1, 10, "p5_first");
    cmd_tready = 1'b0;
    wait_valid(5, "p5_stalled");
    cmd_tready = 1'b1;
    sts_q.push_back('{cyc, 8'h80});
    wait_acc(2, 3, "p5_same_cycle_accept");
    tick(12);
    check("p5_same_cycle_credit", 72'(acc_cnt), 72'd3);
    cmd_tready = 1'b0;
    sts_q.push_back('{cyc, 8'h81});
    wait_valid(6, "p5_issue_pending");
    wait_done_empty(4, "p5_done");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("p5_async_tvalid", 72'(cmd_tvalid), 72'd0);
    check("p5_async_busy",   72'(busy), 72'd0);
    check("p5_async_count",  72'(done_count), 72'd0);
    check("p5_async_block",  72'(done_block), 72'd0);
    check("p5_async_err",    72'(err), 72'd0);
    check("p5_async_stsrdy", 72'(sts_tready), 72'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
